// File: rtl/rule_port_filter_pkg.sv
// rule_port_filter_pkg: shared types and latencies for the rule port-group filter
package rule_port_filter_pkg;
  localparam int PG_RANGE_W = 66;
  localparam int R2P_LAT = 2;
  localparam int PGR_LAT = 2;
  typedef struct packed {
    logic tcp_en;
    logic udp_en;
    logic [15:0] src_lo;
    logic [15:0] src_hi;
    logic [15:0] dst_lo;
    logic [15:0] dst_hi;
  } pg_range_t;
endpackage

// File: rtl/rule_port_filter_if.sv
// rule_port_filter_if: rule stream, table lookup and output bundle of the filter
interface rule_port_filter_if #(
  parameter int RULE_AWIDTH = 16,
  parameter int PG_AWIDTH = 9,
  parameter int NUM_PG = 4
);
  import rule_port_filter_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [RULE_AWIDTH-1:0] in_rule;
  logic [15:0] in_src_port;
  logic [15:0] in_dst_port;
  logic in_tcp;
  logic [RULE_AWIDTH-1:0] r2p_addr;
  logic [NUM_PG*PG_AWIDTH-1:0] r2p_data;
  logic [NUM_PG*PG_AWIDTH-1:0] pgr_addr;
  logic [NUM_PG*PG_RANGE_W-1:0] pgr_data;
  logic out_valid;
  logic out_ready;
  logic [RULE_AWIDTH-1:0] out_rule;
  logic [31:0] stat_match;
  logic [31:0] stat_drop;
  modport master (
    output in_valid, in_rule, in_src_port, in_dst_port, in_tcp, r2p_data, pgr_data, out_ready,
    input in_ready, r2p_addr, pgr_addr, out_valid, out_rule, stat_match, stat_drop
  );
  modport slave (
    input in_valid, in_rule, in_src_port, in_dst_port, in_tcp, r2p_data, pgr_data, out_ready,
    output in_ready, r2p_addr, pgr_addr, out_valid, out_rule, stat_match, stat_drop
  );
endinterface

// File: rtl/rule_port_filter_pg_range_check.sv
// rule_port_filter_pg_range_check: registered protocol and port-range hit for one port group
module rule_port_filter_pg_range_check
  import rule_port_filter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic slot_valid,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic tcp,
  input  pg_range_t rng,
  output logic hit
);
  // inclusive unsigned ranges; an inverted range can never satisfy both bounds
  always_ff @(posedge clk)
    hit <= rst ? 1'b0 : slot_valid & (tcp ? rng.tcp_en : rng.udp_en) &
           (src_port >= rng.src_lo) & (src_port <= rng.src_hi) &
           (dst_port >= rng.dst_lo) & (dst_port <= rng.dst_hi);
endmodule

// File: rtl/rule_port_filter.sv
// rule_port_filter: forwards rules whose port groups match the packet, drops and counts the rest
module rule_port_filter
  import rule_port_filter_pkg::*;
#(
  parameter int RULE_AWIDTH = 16,
  parameter int PG_AWIDTH = 9,
  parameter int NUM_PG = 4,
  parameter int OUT_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  rule_port_filter_if.slave bus
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
  logic [CW-1:0] credits;
  logic accept, push, drop, pop, mem_pop, match;
  logic [6:0] sv;
  logic [RULE_AWIDTH-1:0] sr [7];
  logic [15:0] ssp [6];
  logic [15:0] sdp [6];
  logic [5:0] stcp;
  logic [NUM_PG-1:0] slot_v [3];
  logic [NUM_PG-1:0] hit;
  logic [RULE_AWIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  assign bus.in_ready = !rst && credits < DEPTH_C;
  assign accept = bus.in_valid & bus.in_ready;
  assign bus.r2p_addr = bus.in_rule - RULE_AWIDTH'(1);
  assign match = |hit;
  assign push = sv[6] & match;
  assign drop = sv[6] & !match;
  assign pop = bus.out_valid & bus.out_ready;
  assign mem_pop = (cnt != '0) & (!bus.out_valid | bus.out_ready);
  // non-stalling shift of accepted rules; only the valids need clearing
  always_ff @(posedge clk) begin
    sv <= rst ? '0 : {sv[5:0], accept};
    stcp <= {stcp[4:0], bus.in_tcp};
    sr[0] <= bus.in_rule;
    ssp[0] <= bus.in_src_port;
    sdp[0] <= bus.in_dst_port;
    for (int i = 1; i < 7; i++) sr[i] <= sr[i-1];
    for (int i = 1; i < 6; i++) begin
      ssp[i] <= ssp[i-1];
      sdp[i] <= sdp[i-1];
    end
  end
  // turn returned pg IDs into range-table addresses and slot valids, then age the valids to meet range data
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PG; i++) begin
      bus.pgr_addr[i*PG_AWIDTH +: PG_AWIDTH] <= rst ? '0 : bus.r2p_data[i*PG_AWIDTH +: PG_AWIDTH] - PG_AWIDTH'(1);
      slot_v[0][i] <= !rst & sv[2] & (sr[2] != '0) & (bus.r2p_data[i*PG_AWIDTH +: PG_AWIDTH] != '0);
    end
    slot_v[1] <= rst ? '0 : slot_v[0];
    slot_v[2] <= rst ? '0 : slot_v[1];
  end
  for (genvar g = 0; g < NUM_PG; g++) begin : g_chk
    rule_port_filter_pg_range_check u_chk (
      .clk(clk),
      .rst(rst),
      .slot_valid(slot_v[2][g]),
      .src_port(ssp[5]),
      .dst_port(sdp[5]),
      .tcp(stcp[5]),
      .rng(pg_range_t'(bus.pgr_data[g*PG_RANGE_W +: PG_RANGE_W])),
      .hit(hit[g])
    );
  end
  // credits cover every rule from accept until it is popped or dropped, so the FIFO cannot overflow
  always_ff @(posedge clk) begin
    credits <= rst ? '0 : credits + CW'(accept) - CW'(pop) - CW'(drop);
    bus.stat_match <= rst ? '0 : bus.stat_match + 32'(push);
    bus.stat_drop <= rst ? '0 : bus.stat_drop + 32'(drop);
  end
  // FIFO storage written at retire
  always_ff @(posedge clk)
    if (push) mem[wp] <= sr[6];
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    wp <= rst ? '0 : wp + AW'(push);
    rp <= rst ? '0 : rp + AW'(mem_pop);
    cnt <= rst ? '0 : cnt + CW'(push) - CW'(mem_pop);
    assert (rst || !push || cnt != DEPTH_C || mem_pop);
  end
  // registered output stage, held while the consumer stalls
  always_ff @(posedge clk) begin
    bus.out_valid <= rst ? 1'b0 : mem_pop ? 1'b1 : bus.out_ready ? 1'b0 : bus.out_valid;
    bus.out_rule <= rst ? '0 : mem_pop ? mem[rp] : bus.out_rule;
  end
endmodule

// File: tb/tb_rule_port_filter.sv
// tb_rule_port_filter: directed scoreboard bench with table models for the rule port filter
module tb_rule_port_filter;
  import rule_port_filter_pkg::*;
  localparam int RA = 16;
  localparam int PA = 9;
  localparam int NP = 4;
  localparam int D = 16;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  rule_port_filter_if #(.RULE_AWIDTH(RA), .PG_AWIDTH(PA), .NUM_PG(NP)) bus ();
  rule_port_filter #(.RULE_AWIDTH(RA), .PG_AWIDTH(PA), .NUM_PG(NP), .OUT_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int n_out = 0;
  int exp_m = 0;
  int exp_d = 0;
  logic [RA-1:0] exp_q [$];
  logic [NP*PA-1:0] r2p_mem [64];
  pg_range_t pgr_mem [64];
  logic [RA-1:0] a1, a2, a3;
  logic [NP*PA-1:0] b1, b2;
  logic hold = 0;
  logic [RA-1:0] held;

  // table memories: r2p address seen at accept returns three edges later, pgr address two edges after registration
  always @(posedge clk) begin
    a1 <= bus.r2p_addr;
    a2 <= a1;
    a3 <= a2;
    b1 <= bus.pgr_addr;
    b2 <= b1;
  end
  assign bus.r2p_data = r2p_mem[a3[5:0]];
  always_comb begin
    bus.pgr_data = '0;
    for (int i = 0; i < NP; i++) bus.pgr_data[i*66 +: 66] = pgr_mem[b2[i*PA +: 6]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_match(input logic [15:0] r, input logic [15:0] sp, input logic [15:0] dp, input logic t);
    logic m = 0;
    logic [15:0] rm1 = r - 16'd1;
    if (r == 0) return 0;
    for (int s = 0; s < NP; s++) begin
      logic [PA-1:0] pg = r2p_mem[rm1[5:0]][s*PA +: PA];
      if (pg != 0) begin
        logic [PA-1:0] pm1 = pg - 1;
        pg_range_t e = pgr_mem[pm1[5:0]];
        if ((t ? e.tcp_en : e.udp_en) && sp >= e.src_lo && sp <= e.src_hi && dp >= e.dst_lo && dp <= e.dst_hi) m = 1;
      end
    end
    return m;
  endfunction

  task automatic try_send(input logic [15:0] r, input logic [15:0] sp, input logic [15:0] dp, input logic t, output bit ok);
    bus.in_valid = 1;
    bus.in_rule = r;
    bus.in_src_port = sp;
    bus.in_dst_port = dp;
    bus.in_tcp = t;
    @(negedge clk);
    ok = bus.in_ready;
    if (ok) begin
      if (model_match(r, sp, dp, t)) begin
        exp_q.push_back(r);
        exp_m++;
      end else exp_d++;
    end else stalls++;
    @(posedge clk);
    #1;
    bus.in_valid = 0;
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] sp, input logic [15:0] dp, input logic t);
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) try_send(r, sp, dp, t, ok);
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic set_r2p(input int r, input int slot, input int pg);
    r2p_mem[(r - 1) & 63][slot*PA +: PA] = PA'(pg);
  endtask

  // output monitor: scoreboard pop on each handshake plus hold-stability check
  always @(negedge clk) begin
    if (rst) hold <= 0;
    else begin
      if (hold) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_rule", 64'(bus.out_rule), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("out_rule", 64'(bus.out_rule), 64'(exp_q.pop_front()));
      end
      hold <= bus.out_valid & !bus.out_ready;
      held <= bus.out_rule;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n0;
    bit ok;
    bus.in_valid = 0;
    bus.in_rule = 0;
    bus.in_src_port = 0;
    bus.in_dst_port = 0;
    bus.in_tcp = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 64; i++) begin
      r2p_mem[i] = '0;
      pgr_mem[i] = '0;
    end
    pgr_mem[2] = '{tcp_en: 1'b1, udp_en: 1'b0, src_lo: 16'd0, src_hi: 16'hffff, dst_lo: 16'd80, dst_hi: 16'd80};
    pgr_mem[3] = '{tcp_en: 1'b1, udp_en: 1'b1, src_lo: 16'd100, src_hi: 16'd50, dst_lo: 16'd0, dst_hi: 16'hffff};
    set_r2p(5, 0, 3);
    set_r2p(6, 0, 4);
    set_r2p(8, 2, 3);
    set_r2p(8, 3, 4);
    set_r2p(0, 0, 3);
    for (int r = 10; r < 30; r++) set_r2p(r, 1, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_rule", 64'(bus.out_rule), 0);
    chk("rst_pgr_addr", 64'(bus.pgr_addr), 0);
    chk("rst_stat_match", 64'(bus.stat_match), 0);
    chk("rst_stat_drop", 64'(bus.stat_drop), 0);
    rst = 0;
    #1;
    chk("ready_after_rst", 64'(bus.in_ready), 1);
    send(5, 1234, 80, 1);
    repeat (7) @(posedge clk);
    #1;
    chk("lat_t7_valid", 64'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_t8_valid", 64'(bus.out_valid), 1);
    chk("lat_t8_rule", 64'(bus.out_rule), 5);
    repeat (4) @(posedge clk);
    #1;
    chk("single_stat_match", 64'(bus.stat_match), 1);
    send(5, 1234, 81, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("dst81_stat_drop", 64'(bus.stat_drop), 1);
    chk("dst81_credits", 64'(dut.credits), 0);
    send(5, 1234, 80, 0);
    send(6, 1234, 80, 1);
    send(0, 1234, 80, 1);
    send(7, 1234, 80, 1);
    send(8, 1234, 80, 1);
    send(8, 1234, 80, 0);
    repeat (14) @(posedge clk);
    #1;
    chk("mix_stat_match", 64'(bus.stat_match), 64'(exp_m));
    chk("mix_stat_drop", 64'(bus.stat_drop), 64'(exp_d));
    chk("mix_q_empty", 64'(exp_q.size()), 0);
    chk("mix_credits", 64'(dut.credits), 0);
    bus.out_ready = 0;
    idx = 0;
    n0 = n_out;
    for (int c = 0; c < 40; c++) begin
      if (idx < 20) begin
        try_send(16'(10 + idx), 500, 80, 1, ok);
        if (ok) idx++;
      end else @(posedge clk);
    end
    #1;
    chk("bp_accepts", 64'(idx), 16);
    chk("bp_in_ready", 64'(bus.in_ready), 0);
    chk("bp_no_out", 64'(n_out - n0), 0);
    bus.out_ready = 1;
    for (int c = 0; c < 100 && idx < 20; c++) begin
      try_send(16'(10 + idx), 500, 80, 1, ok);
      if (ok) idx++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("bp_outputs", 64'(n_out - n0), 20);
    chk("bp_q_empty", 64'(exp_q.size()), 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    exp_m = 0;
    exp_d = 0;
    stalls = 0;
    n0 = n_out;
    for (int i = 0; i < 100; i++) send(16'(10 + i % 20), 7, (i % 2) ? 16'd81 : 16'd80, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("rate_stalls", 64'(stalls), 0);
    chk("rate_outputs", 64'(n_out - n0), 50);
    chk("rate_stat_match", 64'(bus.stat_match), 50);
    chk("rate_stat_drop", 64'(bus.stat_drop), 50);
    chk("rate_q_empty", 64'(exp_q.size()), 0);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) send(16'(20 + i), 9, 80, 1);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send(16'(23 + i), 9, (i % 2) ? 16'd81 : 16'd80, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    n0 = n_out;
    chk("midrst_out_valid", 64'(bus.out_valid), 0);
    chk("midrst_stat_match", 64'(bus.stat_match), 0);
    chk("midrst_stat_drop", 64'(bus.stat_drop), 0);
    bus.out_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_stale", 64'(n_out - n0), 0);
    chk("midrst_stat_match_late", 64'(bus.stat_match), 0);
    chk("midrst_stat_drop_late", 64'(bus.stat_drop), 0);
    chk("midrst_credits", 64'(dut.credits), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
